// File: rtl/neuron_bit_serializer.sv
// neuron_bit_serializer
// ---------------------
// Transmit side of the bit-serial neuron interface. Takes one parallel tile of
// Tw*Ti fixed-point neurons per valid/ready handshake and emits it MSB-first,
// one bit per neuron per cycle, with first-slice (sign) and last-slice (bit 0)
// markers for the serial inner-product array.
//
// Build option:
//   NEURON_SER_DBUF_EN  defined   -> shadow buffer S, o_ready = !S_full,
//                                    back-to-back tiles stream with no bubble.
//                       undefined -> no shadow, o_ready only in IDLE, so every
//                                    tile is followed by one IDLE cycle.
//
// Ports:
//   clk           clock, all logic on the rising edge
//   reset         synchronous, active-high
//   i_valid       parallel tile present on i_neurons
//   o_ready       a tile can be accepted this cycle (registered state only)
//   i_neurons     tile; word for lane (w,i) at [N*(w*Ti+i) +: N]
//   i_precision   bits per neuron P; 0 or >N is treated as N
//   i_stall       downstream hold; freezes the active tile, bit index and state
//   o_valid       o_neurons carries a valid bit-slice
//   o_neurons     current bit of every lane; bit (w*Ti+i) = lane (w,i)
//   o_first_cycle current slice is the MSB (sign) slice
//   o_last_cycle  current slice is bit 0
//
// N must not exceed 31 so that the precision and bit index fit in 5 bits.

module neuron_bit_serializer #(
  parameter int N  = 16,
  parameter int Ti = 16,
  parameter int Tw = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [N*Ti*Tw-1:0]   i_neurons,
  input  logic [4:0]           i_precision,
  input  logic                 i_stall,
  output logic                 o_valid,
  output logic [Tw*Ti-1:0]     o_neurons,
  output logic                 o_first_cycle,
  output logic                 o_last_cycle
);

  localparam int LANES  = Ti * Tw;
  localparam int TILE_W = N * LANES;
  localparam logic [4:0] N_P   = 5'(N);
  localparam logic [5:0] N_MAX = 6'(N);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t              state_r, state_s;
  logic [TILE_W-1:0]   a_r, a_s;
  logic [4:0]          k_r, k_s;
  logic [4:0]          pa_r, pa_s;
  logic                xfer_s;
  logic [4:0]          p_norm_s;
  logic [N-1:0]        lane_word_s;

`ifdef NEURON_SER_DBUF_EN
  logic [TILE_W-1:0]   s_tile_r, s_tile_s;
  logic [4:0]          s_prec_r, s_prec_s;
  logic                s_full_r, s_full_s;
`endif

  // Map a requested precision of 0 or above N onto the full word width.
  function automatic logic [4:0] norm_precision(input logic [4:0] p);
    logic [4:0] r;
    if ((p == 5'd0) || ({1'b0, p} > N_MAX)) begin
      r = N_P;
    end else begin
      r = p;
    end
    return r;
  endfunction

  assign p_norm_s = norm_precision(i_precision);
  assign xfer_s   = i_valid & o_ready;

  // State and datapath registers; reset discards both the active and shadow tiles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      a_r      <= {TILE_W{1'b0}};
      k_r      <= 5'd0;
      pa_r     <= 5'd0;
`ifdef NEURON_SER_DBUF_EN
      s_tile_r <= {TILE_W{1'b0}};
      s_prec_r <= 5'd0;
      s_full_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      a_r      <= a_s;
      k_r      <= k_s;
      pa_r     <= pa_s;
`ifdef NEURON_SER_DBUF_EN
      s_tile_r <= s_tile_s;
      s_prec_r <= s_prec_r == s_prec_s ? s_prec_r : s_prec_s;
      s_full_r <= s_full_s;
`endif
    end
  end

  // Next-state logic: load, bit advance, tile end and shadow-buffer handling.
  always_comb begin
    state_s  = state_r;
    a_s      = a_r;
    k_s      = k_r;
    pa_s     = pa_r;
`ifdef NEURON_SER_DBUF_EN
    s_tile_s = s_tile_r;
    s_prec_s = s_prec_r;
    s_full_s = s_full_r;
`endif
    case (state_r)
      ST_IDLE: begin
        // The shadow is always empty in IDLE, so a transfer goes straight to A.
        if (xfer_s) begin
          a_s     = i_neurons;
          pa_s    = p_norm_s;
          k_s     = p_norm_s - 5'd1;
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (!i_stall && (k_r == 5'd0)) begin
          // Tile end: pick up the next tile if one is waiting, else go idle.
`ifdef NEURON_SER_DBUF_EN
          if (s_full_r) begin
            a_s      = s_tile_r;
            pa_s     = s_prec_r;
            k_s      = s_prec_r - 5'd1;
            s_full_s = 1'b0;
          end else if (xfer_s) begin
            // Last slice and a new transfer coincide with S empty: bypass S.
            a_s  = i_neurons;
            pa_s = p_norm_s;
            k_s  = p_norm_s - 5'd1;
          end else begin
            state_s = ST_IDLE;
          end
`else
          state_s = ST_IDLE;
`endif
        end else begin
          if (!i_stall) begin
            k_s = k_r - 5'd1;
          end else begin
            k_s = k_r;
          end
`ifdef NEURON_SER_DBUF_EN
          // Stall never blocks filling the shadow buffer.
          if (xfer_s) begin
            s_tile_s = i_neurons;
            s_prec_s = p_norm_s;
            s_full_s = 1'b1;
          end else begin
            s_full_s = s_full_r;
          end
`endif
        end
      end
      default: begin
        state_s = ST_IDLE;
        k_s     = 5'd0;
      end
    endcase
  end

  // Output decode from registered state only; everything but o_ready is 0 in IDLE.
  always_comb begin
    o_valid       = 1'b0;
    o_first_cycle = 1'b0;
    o_last_cycle  = 1'b0;
    o_neurons     = {LANES{1'b0}};
    lane_word_s   = {N{1'b0}};
`ifdef NEURON_SER_DBUF_EN
    o_ready       = ~s_full_r;
`else
    o_ready       = (state_r == ST_IDLE);
`endif
    if (state_r == ST_SHIFT) begin
      o_valid       = 1'b1;
      o_first_cycle = (k_r == (pa_r - 5'd1));
      o_last_cycle  = (k_r == 5'd0);
      for (int j = 0; j < LANES; j++) begin
        // Shift the lane word so bit k lands in position 0.
        lane_word_s  = a_r[N*j +: N] >> k_r;
        o_neurons[j] = lane_word_s[0];
      end
    end else begin
      o_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_neuron_bit_serializer.sv
// Self-checking bench for neuron_bit_serializer (default parameters).
// Each tile carries lane0 = w0, lane1 = w1, lane(LANES-1) = ~w0, others 0.

module tb_neuron_bit_serializer;

  localparam int N      = 16;
  localparam int TI     = 16;
  localparam int TW     = 16;
  localparam int LANES  = TI * TW;
  localparam int TILE_W = N * LANES;
  localparam int OBS_W  = LANES + 4;

`ifdef NEURON_SER_DBUF_EN
  localparam bit DBUF = 1'b1;
`else
  localparam bit DBUF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              i_valid;
  logic              o_ready;
  logic [TILE_W-1:0] i_neurons;
  logic [4:0]        i_precision;
  logic              i_stall;
  logic              o_valid;
  logic [LANES-1:0]  o_neurons;
  logic              o_first_cycle;
  logic              o_last_cycle;

  int checks   = 0;
  int failures = 0;

  neuron_bit_serializer #(.N(N), .Ti(TI), .Tw(TW)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_neurons     (i_neurons),
    .i_precision   (i_precision),
    .i_stall       (i_stall),
    .o_valid       (o_valid),
    .o_neurons     (o_neurons),
    .o_first_cycle (o_first_cycle),
    .o_last_cycle  (o_last_cycle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  prec;
    logic [15:0] w0;
    logic [15:0] w1;
    int          nslices;
    logic [15:0] seq0;   // expected lane0 bits, MSB-first in the low nslices bits
    logic [15:0] seq1;
  } vec_t;

  vec_t vecs[7];

  wire [OBS_W-1:0] obs = {o_ready, o_valid, o_first_cycle, o_last_cycle, o_neurons};

  function automatic logic [TILE_W-1:0] make_tile(input logic [15:0] w0, input logic [15:0] w1);
    logic [TILE_W-1:0] t;
    t = {TILE_W{1'b0}};
    t[15:0]           = w0;
    t[31:16]          = w1;
    t[TILE_W-1 -: 16] = ~w0;
    return t;
  endfunction

  function automatic logic [OBS_W-1:0] exp_obs(input logic rdy, input logic vld,
                                               input logic first, input logic last,
                                               input logic b0, input logic b1);
    logic [LANES-1:0] n;
    n = {LANES{1'b0}};
    if (vld) begin
      n[0]       = b0;
      n[1]       = b1;
      n[LANES-1] = ~b0;
    end
    return {rdy, vld, first, last, n};
  endfunction

  task automatic check(input string name, input logic [OBS_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, obs, exp);
    end
  endtask

  // One tile from the table: handshake, every slice, then the idle cycle after it.
  task automatic run_vec(input vec_t v, input string tag);
    logic [15:0] s0;
    logic [15:0] s1;
    s0 = v.seq0;
    s1 = v.seq1;
    @(negedge clk);
    check({tag, "_pre_idle"}, exp_obs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    i_valid     = 1'b1;
    i_neurons   = make_tile(v.w0, v.w1);
    i_precision = v.prec;
    for (int s = 0; s < v.nslices; s++) begin
      @(negedge clk);
      i_valid = 1'b0;
      check($sformatf("%s_slice%0d", tag, s),
            exp_obs(DBUF, 1'b1, s == 0, s == v.nslices - 1,
                    s0[v.nslices-1-s], s1[v.nslices-1-s]));
    end
    @(negedge clk);
    check({tag, "_post_idle"}, exp_obs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    vec_t after_rst;
    logic [15:0] wa0, wa1, wb0, wb1;
    int b_start, drop_n, k;
    bit in_a, in_b, rdy;
    int kk[11];

    vecs[0] = '{5'd16, 16'h8001, 16'h7FFF, 16, 16'h8001, 16'h7FFF};
    vecs[1] = '{5'd4,  16'hFFFA, 16'h0005, 4,  16'h000A, 16'h0005};
    vecs[2] = '{5'd1,  16'h0001, 16'hFFFE, 1,  16'h0001, 16'h0000};
    vecs[3] = '{5'd0,  16'h1234, 16'hC3A5, 16, 16'h1234, 16'hC3A5};
    vecs[4] = '{5'd20, 16'hA5A5, 16'h0F0F, 16, 16'hA5A5, 16'h0F0F};
    vecs[5] = '{5'd8,  16'h12C3, 16'h003C, 8,  16'h00C3, 16'h003C};
    vecs[6] = '{5'd5,  16'hFFF0, 16'h0011, 5,  16'h0010, 16'h0011};
    after_rst = '{5'd4, 16'h0003, 16'h000C, 4, 16'h0003, 16'h000C};

    reset       = 1'b1;
    i_valid     = 1'b0;
    i_stall     = 1'b0;
    i_neurons   = {TILE_W{1'b0}};
    i_precision = 5'd0;
    repeat (2) @(negedge clk);
    check("reset_state", exp_obs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      run_vec(vecs[v], $sformatf("vec%0d", v));
    end

    // Back-to-back P=8 tiles with i_valid held high.
    wa0 = 16'h12C3; wa1 = 16'h005A;
    wb0 = 16'hFF81; wb1 = 16'h0066;
    b_start = DBUF ? 9 : 10;
    drop_n  = DBUF ? 2 : 10;
    @(negedge clk);
    i_valid     = 1'b1;
    i_neurons   = make_tile(wa0, wa1);
    i_precision = 5'd8;
    for (int n = 1; n <= b_start + 8; n++) begin
      @(negedge clk);
      if (n == 1) i_neurons = make_tile(wb0, wb1);
      if (n == drop_n) i_valid = 1'b0;
      in_a = (n >= 1) && (n <= 8);
      in_b = (n >= b_start) && (n < b_start + 8);
      if (DBUF) rdy = !((n >= 2) && (n <= 8));
      else      rdy = !(in_a || in_b);
      if (in_a) begin
        k = 8 - n;
        check($sformatf("b2b_a%0d", n), exp_obs(rdy, 1'b1, k == 7, k == 0, wa0[k], wa1[k]));
      end else if (in_b) begin
        k = 7 - (n - b_start);
        check($sformatf("b2b_b%0d", n), exp_obs(rdy, 1'b1, k == 7, k == 0, wb0[k], wb1[k]));
      end else begin
        check($sformatf("b2b_idle%0d", n), exp_obs(rdy, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
    end

    // Stall for 3 cycles on slice 5 of a P=8 tile.
    wa0 = 16'h00B4; wa1 = 16'h0F69;
    kk = '{7, 6, 5, 4, 3, 3, 3, 3, 2, 1, 0};
    @(negedge clk);
    i_valid     = 1'b1;
    i_neurons   = make_tile(wa0, wa1);
    i_precision = 5'd8;
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      i_valid = 1'b0;
      if (n == 5) i_stall = 1'b1;
      if (n == 8) i_stall = 1'b0;
      k = kk[n-1];
      check($sformatf("stall_n%0d", n), exp_obs(DBUF, 1'b1, k == 7, k == 0, wa0[k], wa1[k]));
    end
    @(negedge clk);
    check("stall_idle", exp_obs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

    // Reset during slice 3 of a P=16 tile, with a second tile offered for the shadow.
    wa0 = 16'hA5F0; wa1 = 16'h1234;
    @(negedge clk);
    i_valid     = 1'b1;
    i_neurons   = make_tile(wa0, wa1);
    i_precision = 5'd16;
    @(negedge clk);
    i_neurons = make_tile(16'hFFFF, 16'hFFFF);
    check("rst_s1", exp_obs(DBUF, 1'b1, 1'b1, 1'b0, wa0[15], wa1[15]));
    @(negedge clk);
    i_valid = 1'b0;
    check("rst_s2", exp_obs(1'b0, 1'b1, 1'b0, 1'b0, wa0[14], wa1[14]));
    @(negedge clk);
    check("rst_s3", exp_obs(1'b0, 1'b1, 1'b0, 1'b0, wa0[13], wa1[13]));
    reset = 1'b1;
    @(negedge clk);
    check("rst_clear", exp_obs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    reset = 1'b0;
    run_vec(after_rst, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
